// File: rtl/bulk_arb_pkg.sv
// Shared definitions for the bulk IN packet arbiter: FSM state encodings,
// the header tag nibble and the largest supported source count.
package bulk_arb_pkg;

   // Arbiter FSM states; ST_HDR is only reachable when BULK_ARB_HEADER_EN is defined
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_XFER = 2'd2
   } arb_state_t;

   // Upper nibble of the optional per-packet header byte
   localparam logic [3:0] HDR_TAG = 4'hA;

   // Largest source count; the header byte carries the grant index in 4 bits
   localparam int MAX_SRC = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: returns the first asserted request at
// or after the pointer position, wrapping past the top index back to 0.
module rr_priority_select #(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] ptr,
   output logic [NUM_SRC-1:0]         onehot,
   output logic [$clog2(NUM_SRC)-1:0] idx,
   output logic                       found
);

   localparam int IDX_W = $clog2(NUM_SRC);

   // Scan all positions starting at ptr; the first hit wins
   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_SRC) begin
            j = j - NUM_SRC;
         end
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/bulk_in_packet_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_SRC byte-wide AXI4-Stream
// producers onto the single bulk IN stream of the USB core. Output packets are
// cut at MAX_PKT bytes; a cut source keeps its remaining bytes for a later packet.
// Optional feature macro: BULK_ARB_HEADER_EN (prefixes each packet with the
// byte {HDR_TAG, grant index}; that byte counts toward MAX_PKT).
module bulk_in_packet_arbiter
   import bulk_arb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int MAX_PKT = 512
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NUM_SRC-1:0]     s_axis_tvalid_i,
   output logic [NUM_SRC-1:0]     s_axis_tready_o,
   input  logic [NUM_SRC-1:0]     s_axis_tlast_i,
   input  logic [8*NUM_SRC-1:0]   s_axis_tdata_i,
   output logic                   m_axis_tvalid_o,
   input  logic                   m_axis_tready_i,
   output logic                   m_axis_tlast_o,
   output logic [7:0]             m_axis_tdata_o,
   output logic [NUM_SRC-1:0]     grant_o,
   output logic                   busy_o
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(MAX_PKT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef BULK_ARB_HEADER_EN
   localparam arb_state_t ST_FIRST = ST_HDR;
`else
   localparam arb_state_t ST_FIRST = ST_XFER;
`endif

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] grant_nxt;
   logic [IDX_W-1:0]   gidx;
   logic [IDX_W-1:0]   gidx_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_nxt;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;

   logic [NUM_SRC-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic               beat_done;

`ifdef BULK_ARB_HEADER_EN
   logic [$clog2(MAX_SRC)-1:0] hdr_idx;
   assign hdr_idx = ($clog2(MAX_SRC))'(gidx);
`endif

   rr_priority_select #(
      .NUM_SRC (NUM_SRC)
   ) u_rr (
      .req    (s_axis_tvalid_i),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   assign grant_o = grant;
   assign busy_o  = (state != ST_IDLE);

   // State, grant, round-robin pointer and byte counter registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= ST_IDLE;
         grant  <= '0;
         gidx   <= '0;
         rr_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         gidx   <= gidx_nxt;
         rr_ptr <= rr_nxt;
         count  <= count_nxt;
      end
   end

   // Next-state logic and stream muxing; m_tvalid never looks at m_tready
   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      gidx_nxt        = gidx;
      rr_nxt          = rr_ptr;
      count_nxt       = count;
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      m_axis_tdata_o  = '0;
      s_axis_tready_o = '0;
      beat_done       = 1'b0;

      case (state)
         ST_IDLE: begin
            // Register the pick; no data moves during the arbitration cycle
            if (pick_found) begin
               grant_nxt = pick_onehot;
               gidx_nxt  = pick_idx;
               count_nxt = '0;
               state_nxt = ST_FIRST;
            end
         end

`ifdef BULK_ARB_HEADER_EN
         ST_HDR: begin
            // Header occupies the first byte slot of the packet; sources are held off
            m_axis_tvalid_o = 1'b1;
            m_axis_tdata_o  = {HDR_TAG, hdr_idx};
            beat_done       = m_axis_tready_i;
            if (beat_done) begin
               count_nxt = count + CNT_ONE;
               state_nxt = ST_XFER;
            end
         end
`endif

         ST_XFER: begin
            m_axis_tvalid_o = s_axis_tvalid_i[gidx];
            m_axis_tdata_o  = s_axis_tdata_i[int'(gidx)*8 +: 8];
            // A full packet is closed towards the core even if the source is mid-frame
            m_axis_tlast_o  = s_axis_tlast_i[gidx] | (count == CNT_LAST);
            s_axis_tready_o = grant & {NUM_SRC{m_axis_tready_i}};
            beat_done       = m_axis_tvalid_o & m_axis_tready_i;
            if (beat_done) begin
               if (m_axis_tlast_o) begin
                  state_nxt = ST_IDLE;
                  count_nxt = '0;
                  grant_nxt = '0;
                  gidx_nxt  = '0;
                  rr_nxt    = (gidx == IDX_LAST) ? '0 : gidx + IDX_ONE;
               end else begin
                  count_nxt = count + CNT_ONE;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            count_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_bulk_in_packet_arbiter.sv
`timescale 1ns/1ps
module tb_bulk_in_packet_arbiter;

   localparam int NUM_SRC = 4;
   localparam int MAX_PKT = 512;
`ifdef BULK_ARB_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif

   logic                 aclk = 1'b0;
   logic                 aresetn = 1'b0;
   logic [NUM_SRC-1:0]   s_tvalid = '0;
   logic [NUM_SRC-1:0]   s_tready;
   logic [NUM_SRC-1:0]   s_tlast = '0;
   logic [8*NUM_SRC-1:0] s_tdata = '0;
   logic                 m_tvalid;
   logic                 m_tready = 1'b0;
   logic                 m_tlast;
   logic [7:0]           m_tdata;
   logic [NUM_SRC-1:0]   grant;
   logic                 busy;

   bulk_in_packet_arbiter #(
      .NUM_SRC (NUM_SRC),
      .MAX_PKT (MAX_PKT)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .s_axis_tvalid_i (s_tvalid),
      .s_axis_tready_o (s_tready),
      .s_axis_tlast_i  (s_tlast),
      .s_axis_tdata_i  (s_tdata),
      .m_axis_tvalid_o (m_tvalid),
      .m_axis_tready_i (m_tready),
      .m_axis_tlast_o  (m_tlast),
      .m_axis_tdata_o  (m_tdata),
      .grant_o         (grant),
      .busy_o          (busy)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;

   // Per-source byte queues {last, data}: one feeds the driver, one the scoreboard
   logic [8:0] drvq [NUM_SRC][$];
   logic [8:0] expq [NUM_SRC][$];
   logic [NUM_SRC-1:0] gap_en = '0;
   int ready_mode = 0;

   // Reference model state (transaction level)
   bit m_busy, arb_pend, hdr_pend, prev_stall;
   int cur, arb_src, ptr, pcnt;
   logic [7:0] prev_data;
   logic prev_last;
   logic [NUM_SRC-1:0] hs_src = '0;

   int pkt_src[$];
   int pkt_len[$];
   logic [7:0] out_data[$];

   function automatic int pick(input logic [NUM_SRC-1:0] tv, input int p);
      for (int k = 0; k < NUM_SRC; k++)
         if (tv[(p + k) % NUM_SRC]) return (p + k) % NUM_SRC;
      return -1;
   endfunction

   function automatic bit all_empty();
      bit e;
      e = !m_busy && !arb_pend && (s_tvalid == '0);
      for (int i = 0; i < NUM_SRC; i++)
         if (drvq[i].size() != 0 || expq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic model_reset();
      m_busy = 0; arb_pend = 0; hdr_pend = 0; prev_stall = 0;
      cur = 0; arb_src = 0; ptr = 0; pcnt = 0;
      hs_src = '0;
   endtask

   task automatic clear_log();
      pkt_src.delete(); pkt_len.delete(); out_data.delete();
   endtask

   task automatic push_byte(input int src, input logic [7:0] d, input logic last);
      drvq[src].push_back({last, d});
      expq[src].push_back({last, d});
   endtask

   task automatic push_pkt(input int src, input int len);
      for (int k = 0; k < len; k++) push_byte(src, 8'($urandom), k == len - 1);
   endtask

   // Compare every DUT output against the model at the falling edge
   task automatic check_cycle();
      logic [NUM_SRC-1:0] tv, oh, exp_rdy;
      logic exp_v, exp_l;
      logic [7:0] exp_d;
      tv = s_tvalid;
      hs_src = s_tvalid & s_tready;
      checks++;
      if (busy !== (grant != '0)) begin
         failures++;
         $display("FAIL busy_vs_grant: busy=%b grant=%b", busy, grant);
      end
      if (arb_pend) begin
         m_busy = 1; cur = arb_src; hdr_pend = (H == 1); pcnt = 0; arb_pend = 0;
      end
      if (!m_busy) begin
         checks++;
         if (grant !== '0 || m_tvalid !== 1'b0 || s_tready !== '0) begin
            failures++;
            $display("FAIL idle_outputs: grant=%b m_tvalid=%b s_tready=%b required 0", grant, m_tvalid, s_tready);
         end
         if (|tv) begin arb_pend = 1; arb_src = pick(tv, ptr); end
         prev_stall = 0;
      end else begin
         oh = '0; oh[cur] = 1'b1;
         checks++;
         if (grant !== oh) begin
            failures++;
            $display("FAIL grant: got %b required %b", grant, oh);
         end
         exp_rdy = hdr_pend ? '0 : (oh & {NUM_SRC{m_tready}});
         checks++;
         if (s_tready !== exp_rdy) begin
            failures++;
            $display("FAIL s_tready: got %b required %b", s_tready, exp_rdy);
         end
         exp_v = hdr_pend ? 1'b1 : tv[cur];
         checks++;
         if (m_tvalid !== exp_v) begin
            failures++;
            $display("FAIL m_tvalid: got %b required %b", m_tvalid, exp_v);
         end
         if (m_tvalid === 1'b1 && exp_v) begin
            if (hdr_pend) begin
               exp_d = {4'hA, 4'(cur)}; exp_l = 1'b0;
            end else if (expq[cur].size() == 0) begin
               exp_d = 8'h00; exp_l = 1'b0;
               checks++; failures++;
               $display("FAIL scoreboard: src %0d presented a beat with nothing expected", cur);
            end else begin
               exp_d = expq[cur][0][7:0];
               exp_l = expq[cur][0][8] | (pcnt == MAX_PKT - 1);
            end
            checks++;
            if (m_tdata !== exp_d || m_tlast !== exp_l) begin
               failures++;
               $display("FAIL beat: src %0d byte %0d got data=%h last=%b required data=%h last=%b",
                        cur, pcnt, m_tdata, m_tlast, exp_d, exp_l);
            end
            if (prev_stall) begin
               checks++;
               if (m_tdata !== prev_data || m_tlast !== prev_last) begin
                  failures++;
                  $display("FAIL stall_stable: got %h/%b required %h/%b", m_tdata, m_tlast, prev_data, prev_last);
               end
            end
            if (m_tready) begin
               out_data.push_back(m_tdata);
               pcnt++;
               if (hdr_pend) hdr_pend = 0;
               else if (expq[cur].size() != 0) void'(expq[cur].pop_front());
               if (exp_l) begin
                  pkt_src.push_back(cur); pkt_len.push_back(pcnt);
                  m_busy = 0; ptr = (cur + 1) % NUM_SRC;
               end
               prev_stall = 0;
            end else begin
               prev_stall = 1; prev_data = m_tdata; prev_last = m_tlast;
            end
         end else begin
            prev_stall = 0;
         end
      end
   endtask

   // Producers advance after a handshake; gaps only appear between beats
   task automatic drive_update();
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hs_src[i]) begin
            if (drvq[i].size() != 0) void'(drvq[i].pop_front());
            s_tvalid[i] = 1'b0;
         end
         if (!s_tvalid[i]) begin
            if (drvq[i].size() > 0 && (!gap_en[i] || $urandom_range(0, 1) == 1)) begin
               s_tvalid[i] = 1'b1;
               s_tdata[8*i +: 8] = drvq[i][0][7:0];
               s_tlast[i] = drvq[i][0][8];
            end else begin
               s_tlast[i] = 1'b0;
            end
         end
      end
      hs_src = '0;
      case (ready_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic tick();
      @(negedge aclk);
      check_cycle();
      @(posedge aclk);
      #1;
      drive_update();
   endtask

   task automatic drain(input int budget, input string name);
      int n;
      bit done;
      n = 0; done = 0;
      while (!done && n < budget) begin
         tick(); n++; done = all_empty();
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_drain: still active after %0d cycles, required idle and empty", name, n);
      end
   endtask

   task automatic apply_reset();
      aresetn = 1'b0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin drvq[i].delete(); expq[i].delete(); end
      model_reset();
      repeat (2) @(posedge aclk);
      #1;
      m_tready = 1'b1;
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      s_tvalid = '1; s_tlast = '1; s_tdata = 32'hDEADBEEF; m_tready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         checks++;
         if ({m_tvalid, m_tlast, m_tdata, s_tready, grant, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h rdy=%b g=%b busy=%b required all 0",
                     m_tvalid, m_tlast, m_tdata, s_tready, grant, busy);
         end
      end
      apply_reset();
   endtask

   task automatic test_basic();
      logic [7:0] exp[$];
      clear_log(); ready_mode = 0; gap_en = '0;
      push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0); push_byte(0, 8'h33, 1);
      drain(50, "basic");
      if (H == 1) exp.push_back(8'hA0);
      exp.push_back(8'h11); exp.push_back(8'h22); exp.push_back(8'h33);
      checks++;
      if (pkt_src.size() != 1 || pkt_src[0] != 0 || pkt_len[0] != 3 + H) begin
         failures++;
         $display("FAIL basic_packet: packets=%0d src=%0d len=%0d required 1 packet src 0 len %0d",
                  pkt_src.size(), (pkt_src.size() > 0) ? pkt_src[0] : -1,
                  (pkt_len.size() > 0) ? pkt_len[0] : -1, 3 + H);
      end
      checks++;
      if (out_data != exp) begin
         failures++;
         $display("FAIL basic_bytes: got %p required %p", out_data, exp);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      clear_log(); ready_mode = 0; gap_en = '0;
      for (int i = 0; i < NUM_SRC; i++) begin push_pkt(i, 2); push_pkt(i, 2); end
      drain(200, "rr");
      checks++;
      if (pkt_src.size() != 2 * NUM_SRC) begin
         failures++;
         $display("FAIL rr_count: got %0d packets required %0d", pkt_src.size(), 2 * NUM_SRC);
      end else begin
         for (int k = 0; k < 2 * NUM_SRC; k++) begin
            checks++;
            if (pkt_src[k] != k % NUM_SRC || pkt_len[k] != 2 + H) begin
               failures++;
               $display("FAIL rr_order: packet %0d src=%0d len=%0d required src=%0d len=%0d",
                        k, pkt_src[k], pkt_len[k], k % NUM_SRC, 2 + H);
            end
         end
      end
   endtask

   task automatic test_split();
      int exp_src[3];
      int exp_len[3];
      clear_log(); ready_mode = 0; gap_en = '0;
      for (int k = 0; k < 1000; k++) push_byte(2, 8'(k) ^ 8'h5A, k == 999);
      repeat (4) tick();
      push_pkt(1, 2);
      drain(3000, "split");
      exp_src = '{2, 1, 2};
      exp_len = '{MAX_PKT, 2 + H, 1000 - (MAX_PKT - H) + H};
      checks++;
      if (pkt_src.size() != 3) begin
         failures++;
         $display("FAIL split_count: got %0d packets required 3", pkt_src.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (pkt_src[k] != exp_src[k] || pkt_len[k] != exp_len[k]) begin
               failures++;
               $display("FAIL split_packet: packet %0d src=%0d len=%0d required src=%0d len=%0d",
                        k, pkt_src[k], pkt_len[k], exp_src[k], exp_len[k]);
            end
         end
      end
   endtask

   task automatic test_ready_toggle();
      int total, npkt, len, got;
      clear_log(); ready_mode = 1; gap_en = 4'b0010;
      total = 0; npkt = 3;
      for (int p = 0; p < npkt; p++) begin
         len = $urandom_range(1, 12); total += len; push_pkt(1, len);
      end
      drain(1000, "toggle");
      got = 0;
      foreach (pkt_len[k]) got += pkt_len[k];
      checks++;
      if (got != total + H * npkt || pkt_src.size() != npkt) begin
         failures++;
         $display("FAIL toggle_bytes: got %0d bytes in %0d packets required %0d in %0d",
                  got, pkt_src.size(), total + H * npkt, npkt);
      end
      ready_mode = 0; gap_en = '0;
   endtask

   task automatic test_reset_midpkt();
      int n;
      clear_log(); ready_mode = 0; gap_en = '0;
      push_pkt(2, 1);
      drain(50, "pre_reset");
      clear_log();
      push_pkt(0, 20);
      n = 0;
      while (out_data.size() < 7 + H && n < 100) begin tick(); n++; end
      checks++;
      if (out_data.size() < 7 + H) begin
         failures++;
         $display("FAIL midpkt_progress: got %0d bytes required %0d", out_data.size(), 7 + H);
      end
      aresetn = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({m_tvalid, m_tlast, m_tdata, s_tready, grant, busy} !== '0) begin
            failures++;
            $display("FAIL midpkt_reset_outputs: got v=%b l=%b d=%h rdy=%b g=%b busy=%b required all 0",
                     m_tvalid, m_tlast, m_tdata, s_tready, grant, busy);
         end
         @(negedge aclk);
      end
      apply_reset();
      clear_log();
      push_byte(3, 8'h33, 1);
      push_byte(0, 8'h77, 1);
      drain(50, "post_reset");
      checks++;
      if (pkt_src.size() != 2 || pkt_src[0] != 0 || pkt_src[1] != 3) begin
         failures++;
         $display("FAIL post_reset_order: got %p required '{0, 3}", pkt_src);
      end
   endtask

   task automatic test_header();
      logic [7:0] exp[$];
      clear_log(); ready_mode = 0; gap_en = '0;
      push_byte(3, 8'h5C, 1);
      drain(50, "single_byte");
      if (H == 1) exp.push_back(8'hA3);
      exp.push_back(8'h5C);
      checks++;
      if (out_data != exp || pkt_src.size() != 1 || pkt_len[0] != 1 + H) begin
         failures++;
         $display("FAIL single_byte: got %p in %0d packets required %p in 1", out_data, pkt_src.size(), exp);
      end
   endtask

   task automatic test_random();
      int total, npkt, len, got;
      bit oversize;
      clear_log(); ready_mode = 2; gap_en = 4'($urandom) | 4'b0001;
      total = 0; npkt = 0; oversize = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int p = 0; p < $urandom_range(1, 3); p++) begin
            len = $urandom_range(1, 40); total += len; npkt++; push_pkt(i, len);
         end
      end
      push_pkt(0, 530); total += 530;
      drain(20000, "random");
      got = 0;
      foreach (pkt_len[k]) begin
         got += pkt_len[k];
         if (pkt_len[k] > MAX_PKT) oversize = 1;
      end
      checks++;
      if (got != total + H * pkt_len.size() || oversize) begin
         failures++;
         $display("FAIL random_totals: got %0d bytes oversize=%0d required %0d bytes none oversize",
                  got, oversize, total + H * pkt_len.size());
      end
      checks++;
      if (pkt_len.size() != npkt + 2) begin
         failures++;
         $display("FAIL random_packets: got %0d packets required %0d", pkt_len.size(), npkt + 2);
      end
      ready_mode = 0; gap_en = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_round_robin();
      test_split();
      test_ready_toggle();
      test_reset_midpkt();
      test_header();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
